// File: rtl/regfile_wr_arb.sv
// Round-robin write-port arbiter for a 4-requester register file with a
// registered write port and an 8-entry pending-write scoreboard.
module regfile_wr_arb #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [2:0]        waddr0,
  input  logic [2:0]        waddr1,
  input  logic [2:0]        waddr2,
  input  logic [2:0]        waddr3,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] wdata3,
  output logic [3:0]        gnt,
  output logic              rf_wen,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              resv_valid,
  input  logic [2:0]        resv_addr,
  input  logic              flush,
  output logic [7:0]        busy
);

  localparam int NREQ = 4;

  logic [2:0]        waddr_arr [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  logic [1:0]        last_winner_q, last_winner_d;
  logic              rf_wen_q, rf_wen_d;
  logic [2:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [7:0]        busy_q, busy_d;

  logic              grant_any;
  logic [1:0]        win_idx;
  logic [1:0]        cand;

  assign waddr_arr[0] = waddr0;
  assign waddr_arr[1] = waddr1;
  assign waddr_arr[2] = waddr2;
  assign waddr_arr[3] = waddr3;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;
  assign wdata_arr[2] = wdata2;
  assign wdata_arr[3] = wdata3;

  // Search from the requester after the last winner; offset 4 wraps back to
  // the last winner itself so it is considered last.
  always_comb begin
    grant_any = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    gnt       = 4'b0000;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_winner_q + 2'(k);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        win_idx   = cand;
      end
    end
    if (!rst_n) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    rf_wen_d      = grant_any;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    busy_d        = busy_q;
    if (grant_any) begin
      last_winner_d              = win_idx;
      rf_waddr_d                 = waddr_arr[win_idx];
      rf_wdata_d                 = wdata_arr[win_idx];
      busy_d[waddr_arr[win_idx]] = 1'b0;
    end
    // A new reservation outranks the completing write; flush outranks both.
    if (resv_valid) begin
      busy_d[resv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_winner_q <= 2'd3;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= 3'd0;
      rf_wdata_q    <= '0;
      busy_q        <= 8'h00;
    end else begin
      last_winner_q <= last_winner_d;
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Testbench for regfile_wr_arb: directed vector table for the documented
// scenarios, then randomized traffic against a behavioural reference model.
module tb_regfile_wr_arb;

  localparam int DATA_W = 64;
  localparam logic [11:0] DEF_WA = {3'd3, 3'd2, 3'd1, 3'd0};

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [2:0]        waddrV [4];
  logic [DATA_W-1:0] wdataV [4];
  logic [3:0]        gnt;
  logic              rf_wen;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              resv_valid;
  logic [2:0]        resv_addr;
  logic              flush;
  logic [7:0]        busy;

  int errors;
  int checks;

  regfile_wr_arb #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .waddr0(waddrV[0]), .waddr1(waddrV[1]), .waddr2(waddrV[2]), .waddr3(waddrV[3]),
    .wdata0(wdataV[0]), .wdata1(wdataV[1]), .wdata2(wdataV[2]), .wdata3(wdataV[3]),
    .gnt(gnt), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .resv_valid(resv_valid), .resv_addr(resv_addr), .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [3:0]        req;
    logic [11:0]       wa;
    logic [DATA_W-1:0] wd [4];
    logic              resv;
    logic [2:0]        raddr;
    logic              flush;
    logic [3:0]        eGnt;
    logic              eWen;
    logic [2:0]        eAddr;
    logic [DATA_W-1:0] eData;
    logic [7:0]        eBusy;
  } vec_t;

  vec_t vecQ [$];

  // Reference model state: plain integers and bit vectors per the arbitration rules.
  int                mLast;
  logic              mWen;
  logic [2:0]        mAddr;
  logic [DATA_W-1:0] mData;
  logic [7:0]        mBusy;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic addRow(input logic rst, input logic [3:0] rq, input logic [11:0] wa,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3,
                        input logic rv, input logic [2:0] ra, input logic fl,
                        input logic [3:0] eg, input logic ew, input logic [2:0] ea,
                        input logic [DATA_W-1:0] ed, input logic [7:0] eb);
    vec_t v;
    v.rst = rst; v.req = rq; v.wa = wa;
    v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2; v.wd[3] = d3;
    v.resv = rv; v.raddr = ra; v.flush = fl;
    v.eGnt = eg; v.eWen = ew; v.eAddr = ea; v.eData = ed; v.eBusy = eb;
    vecQ.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n      = v.rst;
    req        = v.req;
    for (int i = 0; i < 4; i++) begin
      waddrV[i] = v.wa[i*3 +: 3];
      wdataV[i] = v.wd[i];
    end
    resv_valid = v.resv;
    resv_addr  = v.raddr;
    flush      = v.flush;
  endtask

  function automatic int modelGrant(input logic [3:0] r, input logic rst, input int last);
    if (!rst) return -1;
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return (last + off) % 4;
    end
    return -1;
  endfunction

  task automatic modelEdge(input int g);
    if (!rst_n) begin
      mLast = 3; mWen = 1'b0; mAddr = '0; mData = '0; mBusy = 8'h00;
    end else begin
      mWen = (g >= 0);
      if (g >= 0) begin
        mLast = g;
        mAddr = waddrV[g];
        mData = wdataV[g];
        mBusy[waddrV[g]] = 1'b0;
      end
      if (resv_valid) mBusy[resv_addr] = 1'b1;
      if (flush) mBusy = 8'h00;
    end
  endtask

  initial begin
    logic [3:0]        held;
    int                g;
    logic [3:0]        expG;
    vec_t              v;

    errors = 0;
    checks = 0;

    // Reset sequence with all requesters active: no grant may escape.
    v.rst = 1'b0; v.req = 4'b1111; v.wa = DEF_WA;
    for (int i = 0; i < 4; i++) v.wd[i] = 64'h100 + 64'(i);
    v.resv = 1'b1; v.raddr = 3'd5; v.flush = 1'b0;
    applyStimulus(v);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 64'(gnt), 64'h0);
    checkOutput("reset_wen", 64'(rf_wen), 64'h0);
    checkOutput("reset_waddr", 64'(rf_waddr), 64'h0);
    checkOutput("reset_wdata", rf_wdata, 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);

    addRow(1, 4'b1111, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0001, 0, 0, 64'h0,   8'h00);
    addRow(1, 4'b1111, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0010, 1, 0, 64'h100, 8'h00);
    addRow(1, 4'b1111, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0100, 1, 1, 64'h101, 8'h00);
    addRow(1, 4'b1111, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b1000, 1, 2, 64'h102, 8'h00);
    addRow(1, 4'b1111, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0001, 1, 3, 64'h103, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 1, 0, 64'h100, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 0, 0, 64'h100, 8'h00);
    addRow(0, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 0, 0, 64'h100, 8'h00);
    addRow(1, 4'b0101, {3'd3, 3'd5, 3'd1, 3'd3}, 64'hA, 64'h101, 64'hB, 64'h103, 0, 0, 0, 4'b0001, 0, 0, 64'h0, 8'h00);
    addRow(1, 4'b0100, {3'd3, 3'd5, 3'd1, 3'd3}, 64'hA, 64'h101, 64'hB, 64'h103, 0, 0, 0, 4'b0100, 1, 3, 64'hA, 8'h00);
    addRow(1, 4'b0000, {3'd3, 3'd5, 3'd1, 3'd3}, 64'hA, 64'h101, 64'hB, 64'h103, 0, 0, 0, 4'b0000, 1, 5, 64'hB, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 1, 6, 0, 4'b0000, 0, 5, 64'hB, 8'h00);
    addRow(1, 4'b0010, {3'd3, 3'd2, 3'd6, 3'd0}, 64'h100, 64'hC, 64'h102, 64'h103, 0, 0, 0, 4'b0010, 0, 5, 64'hB, 8'h40);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 1, 6, 64'hC, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 1, 2, 0, 4'b0000, 0, 6, 64'hC, 8'h00);
    addRow(1, 4'b0001, {3'd3, 3'd2, 3'd1, 3'd2}, 64'hD, 64'h101, 64'h102, 64'h103, 1, 2, 0, 4'b0001, 0, 6, 64'hC, 8'h04);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 1, 4, 1, 4'b0000, 1, 2, 64'hD, 8'h04);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 0, 2, 64'hD, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 1, 7, 0, 4'b0000, 0, 2, 64'hD, 8'h00);
    addRow(1, 4'b0010, DEF_WA, 64'h100, 64'hE, 64'h102, 64'h103, 0, 0, 0, 4'b0010, 0, 2, 64'hD, 8'h80);
    addRow(0, 4'b1000, {3'd7, 3'd2, 3'd1, 3'd0}, 64'h100, 64'h101, 64'h102, 64'hF, 1, 3, 0, 4'b0000, 1, 1, 64'hE, 8'h80);
    addRow(1, 4'b1000, {3'd7, 3'd2, 3'd1, 3'd0}, 64'h100, 64'h101, 64'h102, 64'hF, 0, 0, 0, 4'b1000, 0, 0, 64'h0, 8'h00);
    addRow(1, 4'b0000, DEF_WA, 64'h100, 64'h101, 64'h102, 64'h103, 0, 0, 0, 4'b0000, 1, 7, 64'hF, 8'h00);

    @(posedge clk);
    #1;
    for (int r = 0; r < vecQ.size(); r++) begin
      applyStimulus(vecQ[r]);
      #1;
      checkOutput($sformatf("vec%0d_gnt", r), 64'(gnt), 64'(vecQ[r].eGnt));
      checkOutput($sformatf("vec%0d_wen", r), 64'(rf_wen), 64'(vecQ[r].eWen));
      checkOutput($sformatf("vec%0d_waddr", r), 64'(rf_waddr), 64'(vecQ[r].eAddr));
      checkOutput($sformatf("vec%0d_wdata", r), rf_wdata, vecQ[r].eData);
      checkOutput($sformatf("vec%0d_busy", r), 64'(busy), 64'(vecQ[r].eBusy));
      @(posedge clk);
      #1;
    end

    // Randomized traffic: requesters obey the hold-until-granted handshake.
    rst_n = 1'b0; req = 4'b0000; resv_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    modelEdge(-1);
    held = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!held[i] && ($urandom_range(0, 2) != 0)) begin
          held[i]   = 1'b1;
          waddrV[i] = 3'($urandom_range(0, 7));
          wdataV[i] = {32'($urandom), 32'($urandom)};
        end
      end
      req        = held;
      resv_valid = ($urandom_range(0, 1) == 1);
      resv_addr  = 3'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 29) == 0);
      #1;
      g    = modelGrant(req, rst_n, mLast);
      expG = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checkOutput("rand_gnt", 64'(gnt), 64'(expG));
      checkOutput("rand_wen", 64'(rf_wen), 64'(mWen));
      checkOutput("rand_waddr", 64'(rf_waddr), 64'(mAddr));
      checkOutput("rand_wdata", rf_wdata, mData);
      checkOutput("rand_busy", 64'(busy), 64'(mBusy));
      @(posedge clk);
      #1;
      modelEdge(g);
      if (g >= 0) held[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
